router_pkt_tx: RTL and testbench
================================

# router_pkt_tx

Packet source for the router's input port: collects a command (address, length) and its payload from a host-side stream, then drives the header/payload/parity byte sequence onto the router's `pkt_valid`/`data_in` interface, honouring the router's `busy` back-pressure. It is the transmitter counterpart of the router's input-side FSM. It serves as the synthesizable stimulus engine in block-level benches and as the front end in integration.

## Interface
- `FIFO_DEPTH`, 64: payload buffer depth in bytes; must be ≥ 63.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_addr`  in  2  destination port 0..2; 3 is illegal.
- `cmd_len`  in  6  payload length 1..63; 0 is illegal.
- `pl_valid` / `pl_ready`  in/out  1  payload byte handshake.
- `pl_data`  in  8  payload byte.
- `busy`  in  1  router back-pressure.
- `pkt_valid`  out  1  to router `pkt_valid`.
- `pkt_data`  out  8  to router `data_in`.
- `tx_done`  out  1  one-cycle pulse, packet fully accepted.
- `err_cmd`  out  1  one-cycle pulse, illegal command dropped.

## Operation
- States: IDLE, COLLECT, HEADER, PAYLOAD, PARITY.
- IDLE:
  - `cmd_ready`=1.
  - A handshake with a legal command latches addr and len, clears the byte count, seeds `parity` = header = {len, addr}, and moves to COLLECT.
  - An illegal command (addr==3 or len==0) is consumed, pulses `err_cmd` next cycle, and the FSM stays in IDLE.
- COLLECT:
  - `pl_ready`=1 while count < len.
  - Each handshake pushes `pl_data` into the FIFO, XORs it into `parity`, and increments count.
  - On the handshake where count reaches len, the FSM moves to HEADER.
- HEADER: `pkt_valid`=1, `pkt_data`={len, addr}. Advances to PAYLOAD on an edge where `busy`==0.
- PAYLOAD:
  - `pkt_valid`=1, `pkt_data`=FIFO head.
  - Pops on each edge where `busy`==0.
  - The pop of the len-th byte moves the FSM to PARITY.
- PARITY: `pkt_valid`=0, `pkt_data`=`parity`. On an edge where `busy`==0, moves to IDLE and pulses `tx_done` in the next cycle.
- Outside HEADER, PAYLOAD and PARITY, `pkt_data`=8'h00. There are never gaps with `pkt_valid` high, because the payload is fully buffered before the header.
- `pl_valid` outside COLLECT and `cmd_valid` outside IDLE are ignored.
- Arithmetic: parity is the 8-bit XOR of header and all payload bytes. Count is 6 bits and cannot wrap because len ≤ 63 ≤ FIFO_DEPTH.

## Timing
- Reset values:
  - State IDLE, FIFO empty, parity 0.
  - `cmd_ready`=1, `pl_ready`=0, `pkt_valid`=0, `pkt_data`=0, `tx_done`=0, `err_cmd`=0.
- Reset mid-packet: outputs return to reset values immediately (asynchronous); the buffered payload is discarded.
- With `busy` held low, the bus occupancy is exactly len+2 cycles: 1 header, len payload, 1 parity. The header appears the cycle after the last payload handshake.
- `busy` is sampled at each rising edge. A byte is "accepted" only on an edge with `busy`==0; otherwise `pkt_valid` and `pkt_data` hold stable.
- `cmd_ready` rises in the cycle `tx_done` pulses, so a new command can be taken back-to-back.

## Configuration
- `ROUTER_TX_ERR_INJECT_EN` defined:
  - Adds input `err_inject` (1 bit), sampled at command accept.
  - If it is set, the PARITY byte is driven as `~parity`.
- Undefined: the port is absent and parity is always correct.

## Structure
- Shared package `router_pkg`:
  - State enum.
  - Address constants ADDR0..ADDR2 and ADDR_ILLEGAL=2'b11.
  - MAX_PAYLOAD=63.
  - Header pack function {len, addr}.
- Sub-module `router_tx_fifo`: synchronous single-clock FIFO with async reset, push/pop, empty/full, and a data output that shows the head without a pop.

## Test plan
- addr=1, len=3, payload 11,22,33, busy=0 → bus carries 0D(v=1), 11, 22, 33(v=1), 0D(v=0); `tx_done` 1 cycle later.
- Same packet with `busy` high for 2 cycles during payload byte 22 → 22 held 3 cycles; sequence and parity unchanged.
- cmd addr=3 len=5 → `err_cmd` pulse; `pl_ready` and `pkt_valid` never rise; `cmd_ready` stays 1.
- len=63, addr=2, payload 00..3E → 65 bus cycles; header FE; parity equals the XOR of header and all payload bytes.
- `reset` asserted during PAYLOAD byte 10 of 20 → `pkt_valid`=0 immediately; the next packet starts clean with the correct parity.
- With `ROUTER_TX_ERR_INJECT_EN` and err_inject=1 for the first packet → parity byte F2 (~0D); the following packet has correct parity.

Source files
------------

// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the router packet transmitter:
//   - txState_e     : transmitter FSM states
//   - ADDR0..ADDR2  : legal destination ports, ADDR_ILLEGAL marks the unused code
//   - MAX_PAYLOAD   : largest payload length a command may carry
//   - CNT_W         : width of length / byte-count fields
//   - packHeader()  : builds the header byte {len, addr}
//   - isLegalCmd()  : true when a command may be transmitted
// -----------------------------------------------------------------------------
package router_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_HEADER,
      ST_PAYLOAD,
      ST_PARITY
   } txState_e;

   localparam logic [1:0] ADDR0        = 2'd0;
   localparam logic [1:0] ADDR1        = 2'd1;
   localparam logic [1:0] ADDR2        = 2'd2;
   localparam logic [1:0] ADDR_ILLEGAL = 2'b11;

   localparam int MAX_PAYLOAD = 63;
   localparam int CNT_W       = $clog2(MAX_PAYLOAD + 1);

   // Header byte as the router expects it: length in the top six bits,
   // destination port in the bottom two.
   function automatic logic [7:0] packHeader(input logic [CNT_W-1:0] len,
                                             input logic [1:0]       addr);
      return {len, addr};
   endfunction

   // A command is legal when it targets a real port and carries at least
   // one payload byte.
   function automatic logic isLegalCmd(input logic [1:0]       addr,
                                       input logic [CNT_W-1:0] len);
      logic addrOk;
      case (addr)
         ADDR0, ADDR1, ADDR2: addrOk = 1'b1;
         ADDR_ILLEGAL:        addrOk = 1'b0;
         default:             addrOk = 1'b0;
      endcase
      return addrOk && (len != '0);
   endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// -----------------------------------------------------------------------------
// router_pkt_tx_if
// Bundles the command stream, payload stream and router-side bus of the
// packet transmitter.
//   master : host / environment view (drives command, payload and busy)
//   slave  : transmitter view (drives ready signals, bus and status pulses)
// Signals:
//   cmd_valid/cmd_ready/cmd_addr/cmd_len : command handshake
//   pl_valid/pl_ready/pl_data            : payload byte handshake
//   busy                                 : router back-pressure
//   pkt_valid/pkt_data                   : router input bus
//   tx_done/err_cmd                      : single-cycle status pulses
// -----------------------------------------------------------------------------
interface router_pkt_tx_if;
   import router_pkg::*;

   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_addr;
   logic [CNT_W-1:0] cmd_len;
   logic             pl_valid;
   logic             pl_ready;
   logic [7:0]       pl_data;
   logic             busy;
   logic             pkt_valid;
   logic [7:0]       pkt_data;
   logic             tx_done;
   logic             err_cmd;

   modport master (
      output cmd_valid, cmd_addr, cmd_len, pl_valid, pl_data, busy,
      input  cmd_ready, pl_ready, pkt_valid, pkt_data, tx_done, err_cmd
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_len, pl_valid, pl_data, busy,
      output cmd_ready, pl_ready, pkt_valid, pkt_data, tx_done, err_cmd
   );

endinterface

// File: rtl/router_tx_fifo.sv
// -----------------------------------------------------------------------------
// router_tx_fifo
// Single-clock FIFO buffering one packet's payload.
// Ports:
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   push_i        : write pushData_i (ignored when full)
//   pop_i         : discard the head entry (ignored when empty)
//   headData_o    : current head entry, visible without popping
//   empty_o/full_o: occupancy flags
// -----------------------------------------------------------------------------
module router_tx_fifo #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] pushData_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] headData_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q, rdPtr_q;
   logic [AW:0]      count_q;
   logic             doPush, doPop;

   // Pointers wrap explicitly so depths that are not a power of two work.
   function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign doPush     = push_i && !full_o;
   assign doPop      = pop_i && !empty_o;
   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == (AW + 1)'(DEPTH));
   assign headData_o = mem_q[rdPtr_q];

   // Pointer and occupancy bookkeeping; reset empties the buffer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= nextPtr(wrPtr_q);
         if (doPop)  rdPtr_q <= nextPtr(rdPtr_q);
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + (AW + 1)'(1);
            2'b01:   count_q <= count_q - (AW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the pointers decide what is valid.
   always_ff @(posedge clock) begin
      if (doPush) mem_q[wrPtr_q] <= pushData_i;
   end

endmodule

// File: rtl/router_pkt_tx.sv
// -----------------------------------------------------------------------------
// router_pkt_tx
// Packet source for a router input port. Accepts a command (addr, len),
// buffers len payload bytes, then sends header, payload and parity to the
// router, stalling whenever busy is high at a clock edge.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   err_inject   : only with ROUTER_TX_ERR_INJECT_EN; sampled at command
//                  accept, inverts the parity byte of that packet
//   bus          : router_pkt_tx_if.slave (command, payload, router bus,
//                  tx_done / err_cmd pulses)
// Parameter:
//   FIFO_DEPTH   : payload buffer depth, must be at least 63
// Optional feature macro: ROUTER_TX_ERR_INJECT_EN
// -----------------------------------------------------------------------------
module router_pkt_tx
   import router_pkg::*;
#(
   parameter int FIFO_DEPTH = 64
) (
   input  logic                 clock,
   input  logic                 reset,
`ifdef ROUTER_TX_ERR_INJECT_EN
   input  logic                 err_inject,
`endif
   router_pkt_tx_if.slave       bus
);

   txState_e         state_q, state_d;
   logic [1:0]       addr_q, addr_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       parity_q, parity_d;
   logic             txDone_q, txDone_d;
   logic             errCmd_q, errCmd_d;
   logic [7:0]       parityByte;
   logic             cmdFire, plFire, fifoPop;
   logic             fifoEmpty, fifoFull;
   logic [7:0]       fifoHead;

`ifdef ROUTER_TX_ERR_INJECT_EN
   logic             inject_q, inject_d;
   assign parityByte = inject_q ? ~parity_q : parity_q;
`else
   assign parityByte = parity_q;
`endif

   assign bus.cmd_ready = (state_q == ST_IDLE);
   assign bus.pl_ready  = (state_q == ST_COLLECT) && (count_q < len_q) && !fifoFull;
   assign bus.pkt_valid = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD);
   assign bus.tx_done   = txDone_q;
   assign bus.err_cmd   = errCmd_q;

   assign cmdFire = bus.cmd_valid && bus.cmd_ready;
   assign plFire  = bus.pl_valid && bus.pl_ready;
   assign fifoPop = (state_q == ST_PAYLOAD) && !bus.busy && !fifoEmpty;

   router_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push_i     (plFire),
      .pushData_i (bus.pl_data),
      .pop_i      (fifoPop),
      .headData_o (fifoHead),
      .empty_o    (fifoEmpty),
      .full_o     (fifoFull)
   );

   // Bus byte mux: header, buffered payload head, or the running parity.
   // The parity byte travels with pkt_valid low, as the router expects.
   always_comb begin
      bus.pkt_data = 8'h00;
      case (state_q)
         ST_HEADER:  bus.pkt_data = packHeader(len_q, addr_q);
         ST_PAYLOAD: bus.pkt_data = fifoHead;
         ST_PARITY:  bus.pkt_data = parityByte;
         default:    bus.pkt_data = 8'h00;
      endcase
   end

   // Next-state logic. count_q is reused: it counts pushes while collecting
   // and is cleared on entry to HEADER so it then counts pops.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      len_d    = len_q;
      count_d  = count_q;
      parity_d = parity_q;
      txDone_d = 1'b0;
      errCmd_d = 1'b0;
`ifdef ROUTER_TX_ERR_INJECT_EN
      inject_d = inject_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cmdFire) begin
               if (isLegalCmd(bus.cmd_addr, bus.cmd_len)) begin
                  addr_d   = bus.cmd_addr;
                  len_d    = bus.cmd_len;
                  count_d  = '0;
                  parity_d = packHeader(bus.cmd_len, bus.cmd_addr);
`ifdef ROUTER_TX_ERR_INJECT_EN
                  inject_d = err_inject;
`endif
                  state_d  = ST_COLLECT;
               end else begin
                  errCmd_d = 1'b1;
               end
            end
         end
         ST_COLLECT: begin
            if (plFire) begin
               count_d  = count_q + CNT_W'(1);
               parity_d = parity_q ^ bus.pl_data;
               if (count_q + CNT_W'(1) == len_q) begin
                  count_d = '0;
                  state_d = ST_HEADER;
               end
            end
         end
         ST_HEADER: begin
            if (!bus.busy) state_d = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            if (fifoPop) begin
               count_d = count_q + CNT_W'(1);
               if (count_q + CNT_W'(1) == len_q) state_d = ST_PARITY;
            end
         end
         ST_PARITY: begin
            if (!bus.busy) begin
               state_d  = ST_IDLE;
               txDone_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; reset abandons any packet in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         len_q    <= '0;
         count_q  <= '0;
         parity_q <= '0;
         txDone_q <= 1'b0;
         errCmd_q <= 1'b0;
`ifdef ROUTER_TX_ERR_INJECT_EN
         inject_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         count_q  <= count_d;
         parity_q <= parity_d;
         txDone_q <= txDone_d;
         errCmd_q <= errCmd_d;
`ifdef ROUTER_TX_ERR_INJECT_EN
         inject_q <= inject_d;
`endif
      end
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// -----------------------------------------------------------------------------
// tb_router_pkt_tx
// Self-checking bench for router_pkt_tx: a table of known packets, hand
// sequences for illegal commands, mid-packet reset and parity inversion
// (ROUTER_TX_ERR_INJECT_EN builds), then random packets compared against a
// byte-sequence model built from the packet format.
// -----------------------------------------------------------------------------
module tb_router_pkt_tx;
   import router_pkg::*;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

`ifdef ROUTER_TX_ERR_INJECT_EN
   localparam bit INJECT_BUILD = 1'b1;
   logic errInject;
`else
   localparam bit INJECT_BUILD = 1'b0;
`endif

   router_pkt_tx_if txIf ();

   router_pkt_tx #(
      .FIFO_DEPTH (64)
   ) dut (
      .clock      (clock),
      .reset      (reset),
`ifdef ROUTER_TX_ERR_INJECT_EN
      .err_inject (errInject),
`endif
      .bus        (txIf)
   );

   int checks   = 0;
   int failures = 0;

   logic [7:0] payloadBuf [64];

   typedef struct {
      logic [1:0] addr;
      int         len;
      bit         ramp;
      bit         gaps;
      int         busyMode;
      int         busyAt;
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] b2;
      logic [7:0] expHdr;
      logic [7:0] expPar;
   } vec_t;

   vec_t vecs [5];

   // One comparison: counts it and reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Sends one legal packet whose payload is in payloadBuf and checks every
   // bus cycle against the expected byte sequence. busyMode: 0 none,
   // 1 random, 2 two busy cycles while byte index busyAt is on the bus.
   // abortAt >= 0 pulses reset while byte index abortAt is on the bus.
   // Entered and left on a falling clock edge.
   task automatic applyStimulus(input logic [1:0] addr, input int len, input bit inject,
                                input bit gaps, input int busyMode, input int busyAt,
                                input int abortAt,
                                output logic [7:0] hdrSeen, output logic [7:0] parSeen);
      logic [7:0] expBytes [$];
      logic [7:0] hdr, par;
      int sent, guard, idx, cycles, busyCnt, busyHeld;
      bit b;

      hdr = 8'((len * 4) + int'(addr));
      par = hdr;
      for (int i = 0; i < len; i++) par = par ^ payloadBuf[i];
      if (inject && INJECT_BUILD) par = ~par;
      expBytes = {};
      expBytes.push_back(hdr);
      for (int i = 0; i < len; i++) expBytes.push_back(payloadBuf[i]);
      expBytes.push_back(par);
      hdrSeen = 8'h00;
      parSeen = 8'h00;

      checkOutput("cmd_ready_idle", txIf.cmd_ready, 1);
      txIf.cmd_valid = 1'b1;
      txIf.cmd_addr  = addr;
      txIf.cmd_len   = 6'(len);
`ifdef ROUTER_TX_ERR_INJECT_EN
      errInject = inject;
`endif
      @(negedge clock);
      txIf.cmd_valid = 1'b0;
`ifdef ROUTER_TX_ERR_INJECT_EN
      errInject = 1'b0;
`endif

      sent  = 0;
      guard = 0;
      while (sent < len && guard < 1000) begin
         checkOutput("collect_pl_ready", txIf.pl_ready, 1);
         checkOutput("collect_pkt_valid", txIf.pkt_valid, 0);
         checkOutput("collect_err_cmd", txIf.err_cmd, 0);
         txIf.pl_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         txIf.pl_data  = txIf.pl_valid ? payloadBuf[sent] : 8'($urandom);
         if (gaps) begin
            txIf.cmd_valid = 1'($urandom_range(0, 1));
            txIf.cmd_addr  = 2'b11;
            txIf.cmd_len   = 6'($urandom);
         end
         @(posedge clock);
         if (txIf.pl_valid) sent++;
         @(negedge clock);
         txIf.pl_valid  = 1'b0;
         txIf.cmd_valid = 1'b0;
         guard++;
      end
      if (sent < len) checkOutput("collect_timeout", sent, len);

      idx      = 0;
      cycles   = 0;
      busyCnt  = 0;
      busyHeld = 0;
      while (idx < len + 2 && cycles < 4000) begin
         if (abortAt >= 0 && idx == abortAt) begin
            #2 reset = 1'b1;
            #1;
            checkOutput("rst_pkt_valid", txIf.pkt_valid, 0);
            checkOutput("rst_pkt_data", txIf.pkt_data, 0);
            checkOutput("rst_cmd_ready", txIf.cmd_ready, 1);
            checkOutput("rst_pl_ready", txIf.pl_ready, 0);
            checkOutput("rst_tx_done", txIf.tx_done, 0);
            @(negedge clock);
            reset          = 1'b0;
            txIf.busy      = 1'b0;
            txIf.cmd_valid = 1'b0;
            txIf.pl_valid  = 1'b0;
            return;
         end
         checkOutput("bus_valid", txIf.pkt_valid, (idx <= len));
         checkOutput("bus_data", txIf.pkt_data, expBytes[idx]);
         checkOutput("bus_cmd_ready", txIf.cmd_ready, 0);
         checkOutput("bus_pl_ready", txIf.pl_ready, 0);
         checkOutput("bus_tx_done", txIf.tx_done, 0);
         if (idx == 0)       hdrSeen = txIf.pkt_data;
         if (idx == len + 1) parSeen = txIf.pkt_data;
         case (busyMode)
            1:       b = ($urandom_range(0, 2) == 0);
            2:       b = (idx == busyAt) && (busyHeld < 2);
            default: b = 1'b0;
         endcase
         if (busyMode == 2 && b) busyHeld++;
         if (b) busyCnt++;
         txIf.busy = b;
         if (gaps) begin
            txIf.cmd_valid = 1'($urandom_range(0, 1));
            txIf.pl_valid  = 1'($urandom_range(0, 1));
         end
         @(posedge clock);
         if (!b) idx++;
         cycles++;
         @(negedge clock);
      end
      txIf.busy      = 1'b0;
      txIf.cmd_valid = 1'b0;
      txIf.pl_valid  = 1'b0;
      checkOutput("bus_cycles", cycles, len + 2 + busyCnt);
      checkOutput("tx_done_pulse", txIf.tx_done, 1);
      checkOutput("done_cmd_ready", txIf.cmd_ready, 1);
      checkOutput("idle_pkt_valid", txIf.pkt_valid, 0);
      checkOutput("idle_pkt_data", txIf.pkt_data, 0);
      @(negedge clock);
      checkOutput("tx_done_width", txIf.tx_done, 0);
   endtask

   // Presents an illegal command for one edge, with payload offered too.
   task automatic applyIllegal(input logic [1:0] addr, input logic [5:0] len);
      checkOutput("ill_cmd_ready", txIf.cmd_ready, 1);
      txIf.cmd_valid = 1'b1;
      txIf.cmd_addr  = addr;
      txIf.cmd_len   = len;
      txIf.pl_valid  = 1'b1;
      txIf.pl_data   = 8'h5A;
      @(negedge clock);
      txIf.cmd_valid = 1'b0;
      checkOutput("err_cmd_pulse", txIf.err_cmd, 1);
      checkOutput("ill_cmd_ready_after", txIf.cmd_ready, 1);
      checkOutput("ill_pl_ready", txIf.pl_ready, 0);
      checkOutput("ill_pkt_valid", txIf.pkt_valid, 0);
      @(negedge clock);
      checkOutput("err_cmd_width", txIf.err_cmd, 0);
      checkOutput("ill_pl_ready_later", txIf.pl_ready, 0);
      checkOutput("ill_pkt_valid_later", txIf.pkt_valid, 0);
      txIf.pl_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] h, p;
      int rl;

      reset          = 1'b1;
      txIf.cmd_valid = 1'b0;
      txIf.cmd_addr  = 2'd0;
      txIf.cmd_len   = 6'd0;
      txIf.pl_valid  = 1'b0;
      txIf.pl_data   = 8'h00;
      txIf.busy      = 1'b0;
`ifdef ROUTER_TX_ERR_INJECT_EN
      errInject = 1'b0;
`endif

      #2;
      checkOutput("reset_cmd_ready", txIf.cmd_ready, 1);
      checkOutput("reset_pl_ready", txIf.pl_ready, 0);
      checkOutput("reset_pkt_valid", txIf.pkt_valid, 0);
      checkOutput("reset_pkt_data", txIf.pkt_data, 0);
      checkOutput("reset_tx_done", txIf.tx_done, 0);
      checkOutput("reset_err_cmd", txIf.err_cmd, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      vecs[0] = '{2'd1,  3, 1'b0, 1'b0, 0, -1, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h0D};
      vecs[1] = '{2'd1,  3, 1'b0, 1'b0, 2,  2, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h0D};
      vecs[2] = '{2'd2, 63, 1'b1, 1'b0, 0, -1, 8'h00, 8'h00, 8'h00, 8'hFE, 8'hC1};
      vecs[3] = '{2'd0,  1, 1'b0, 1'b1, 1, -1, 8'hAA, 8'h00, 8'h00, 8'h04, 8'hAE};
      vecs[4] = '{2'd2,  2, 1'b0, 1'b1, 1, -1, 8'hFF, 8'h01, 8'h00, 8'h0A, 8'hF4};

      for (int v = 0; v < 5; v++) begin
         if (vecs[v].ramp) begin
            for (int i = 0; i < 64; i++) payloadBuf[i] = 8'(i);
         end else begin
            payloadBuf[0] = vecs[v].b0;
            payloadBuf[1] = vecs[v].b1;
            payloadBuf[2] = vecs[v].b2;
         end
         applyStimulus(vecs[v].addr, vecs[v].len, 1'b0, vecs[v].gaps,
                       vecs[v].busyMode, vecs[v].busyAt, -1, h, p);
         checkOutput("table_header", h, vecs[v].expHdr);
         checkOutput("table_parity", p, vecs[v].expPar);
      end

      applyIllegal(2'b11, 6'd5);
      applyIllegal(2'd1, 6'd0);

      for (int i = 0; i < 20; i++) payloadBuf[i] = 8'($urandom);
      applyStimulus(2'd0, 20, 1'b0, 1'b0, 0, -1, 10, h, p);
      payloadBuf[0] = 8'h11;
      payloadBuf[1] = 8'h22;
      payloadBuf[2] = 8'h33;
      applyStimulus(2'd1, 3, 1'b0, 1'b0, 0, -1, -1, h, p);
      checkOutput("post_reset_header", h, 8'h0D);
      checkOutput("post_reset_parity", p, 8'h0D);

`ifdef ROUTER_TX_ERR_INJECT_EN
      applyStimulus(2'd1, 3, 1'b1, 1'b0, 0, -1, -1, h, p);
      checkOutput("inject_parity", p, 8'hF2);
      applyStimulus(2'd1, 3, 1'b0, 1'b0, 0, -1, -1, h, p);
      checkOutput("after_inject_parity", p, 8'h0D);
`endif

      for (int r = 0; r < 24; r++) begin
         if ($urandom_range(0, 4) == 0) begin
            if ($urandom_range(0, 1) == 1) applyIllegal(2'b11, 6'($urandom));
            else                           applyIllegal(2'($urandom_range(0, 2)), 6'd0);
         end else begin
            rl = int'($urandom_range(1, 63));
            for (int i = 0; i < rl; i++) payloadBuf[i] = 8'($urandom);
            applyStimulus(2'($urandom_range(0, 2)), rl, 1'($urandom_range(0, 1)),
                          1'b1, 1, -1, -1, h, p);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
